flit_serializer: RTL and testbench
==================================

FLIT_SERIALIZER -- requirements
Module: flit_serializer

Interface
REQ-001 Parameter: CNT_W, default 16, width of the packet counter.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 reset  input  1  reset, asynchronous, active-high.
REQ-004 fifo_empty  input  1  upstream flit FIFO empty flag.
REQ-005 fifo_rd_en  output  1  pop request to upstream flit FIFO.
REQ-006 fifo_dout  input  48  packed packet {HF[47:32], BF[31:16], TF[15:0]}, valid the cycle after fifo_rd_en.
REQ-007 link_data  output  16  serialized link word.
REQ-008 link_type  output  2  word tag: 00 head, 01 body, 10 tail, 11 checksum.
REQ-009 link_valid  output  1  link_data/link_type valid.
REQ-010 link_ready  input  1  downstream accepts word when high with link_valid.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 pkt_count  output  CNT_W  packets fully sent since reset.

Function
REQ-013 The FSM SHALL have states IDLE, FETCH, HEAD, BODY, TAIL and, with the macro, CSUM.
REQ-014 IDLE: fifo_rd_en SHALL be high exactly when state is IDLE and fifo_empty is low; that cycle SHALL move to FETCH.
REQ-015 IDLE with fifo_empty high SHALL stay in IDLE with fifo_rd_en low.
REQ-016 FETCH: fifo_dout SHALL be latched into a 48-bit hold register; next state HEAD; fifo_rd_en low.
REQ-017 HEAD/BODY/TAIL SHALL drive link_valid=1, link_data=hold[47:32]/hold[31:16]/hold[15:0], link_type=00/01/10.
REQ-018 A word SHALL advance only on link_valid && link_ready; otherwise link_data/link_type SHALL hold stable.
REQ-019 Transitions: HEAD->BODY, BODY->TAIL on handshake; TAIL->IDLE on handshake (TAIL->CSUM with macro).
REQ-020 link_valid SHALL be low in IDLE and FETCH; link_data SHALL be 0 and link_type 00 when link_valid is low.
REQ-021 pkt_count SHALL increment by 1 on the handshake of the last word of a packet, wrapping from all-ones to 0.
REQ-022 Minimum packet period SHALL be 5 cycles (6 with macro) under continuous link_ready and non-empty FIFO.
REQ-023 fifo_empty changes outside IDLE SHALL be ignored; no pop SHALL occur outside IDLE.
REQ-024 link_ready high outside HEAD/BODY/TAIL/CSUM SHALL have no effect.

Reset
REQ-025 Reset asserted SHALL immediately force state IDLE, hold register 0, pkt_count 0, fifo_rd_en 0, link_valid 0, link_data 0, link_type 00, busy 0.
REQ-026 Reset mid-packet SHALL discard the held packet; no further words of it SHALL be emitted after release.
REQ-027 First pop after reset release SHALL occur no earlier than the first rising edge with reset low.

Configuration
REQ-028 Macro FLIT_SERIALIZER_CSUM_EN SHALL, when defined, add state CSUM after TAIL emitting link_data=HF^BF^TF, link_type=11, then IDLE on handshake.
REQ-029 Without FLIT_SERIALIZER_CSUM_EN, CSUM SHALL not exist, type 11 SHALL never be driven, and TAIL handshake SHALL end the packet.

Verification
REQ-030 Reset, FIFO holding 0x1111_2222_3333, link_ready=1 -> words 0x1111/00, 0x2222/01, 0x3333/10 on consecutive cycles, pkt_count=1.
REQ-031 Same packet, link_ready low 3 cycles during BODY -> 0x2222/01 held stable 4 cycles, no duplicate or skipped word.
REQ-032 Two back-to-back packets, FIFO non-empty, link_ready=1 -> second HEAD exactly 5 cycles after first HEAD, pkt_count=2.
REQ-033 Reset asserted during BODY of 0xAAAA_BBBB_CCCC -> outputs zero immediately, next packet 0x0001_0002_0003 emitted from HEAD, pkt_count=1.
REQ-034 With CSUM macro, packet 0x00FF_0F0F_F000 -> fourth word 0xFFF0 tagged 11; without macro, no type 11 word appears.
REQ-035 pkt_count preloaded via 65535 packets then one more -> pkt_count wraps to 0, no other output affected.

Source files
------------

// File: rtl/flit_serializer.sv
// flit_serializer: pops one 48-bit packet {HF,BF,TF} from an upstream FIFO
// and emits it as three 16-bit link words (head/body/tail) with a
// valid/ready handshake. Counts fully sent packets in pkt_count.
// Optional: define FLIT_SERIALIZER_CSUM_EN to append a fourth checksum word
// (HF^BF^TF, tag 11) after the tail.
module flit_serializer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fifo_empty,
  output logic             fifo_rd_en,
  input  logic [47:0]      fifo_dout,
  output logic [15:0]      link_data,
  output logic [1:0]       link_type,
  output logic             link_valid,
  input  logic             link_ready,
  output logic             busy,
  output logic [CNT_W-1:0] pkt_count
);

`ifdef FLIT_SERIALIZER_CSUM_EN
  typedef enum logic [2:0] {IDLE, FETCH, HEAD, BODY, TAIL, CSUM} state_t;
`else
  typedef enum logic [2:0] {IDLE, FETCH, HEAD, BODY, TAIL} state_t;
`endif

  state_t      state, state_n;
  logic [47:0] hold;
  logic        xfer;
  logic        last;

  assign xfer = link_valid & link_ready;
  assign busy = (state != IDLE);

  // State register; reset drops any in-flight packet.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Capture the popped packet in FETCH, when fifo_dout is valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)               hold <= '0;
    else if (state == FETCH) hold <= fifo_dout;
  end

  // Count packets on the handshake of their final word; wraps naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)             pkt_count <= '0;
    else if (xfer && last) pkt_count <= pkt_count + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  // Next-state and link/FIFO outputs; outputs default to the idle (all-zero) values.
  always_comb begin
    state_n    = state;
    fifo_rd_en = 1'b0;
    link_valid = 1'b0;
    link_data  = 16'h0000;
    link_type  = 2'b00;
    last       = 1'b0;
    case (state)
      IDLE: begin
        // Pop is gated by reset so it stays low while reset is held.
        if (!fifo_empty && !reset) begin
          fifo_rd_en = 1'b1;
          state_n    = FETCH;
        end
      end
      FETCH: state_n = HEAD;
      HEAD: begin
        link_valid = 1'b1;
        link_data  = hold[47:32];
        link_type  = 2'b00;
        if (link_ready) state_n = BODY;
      end
      BODY: begin
        link_valid = 1'b1;
        link_data  = hold[31:16];
        link_type  = 2'b01;
        if (link_ready) state_n = TAIL;
      end
      TAIL: begin
        link_valid = 1'b1;
        link_data  = hold[15:0];
        link_type  = 2'b10;
`ifdef FLIT_SERIALIZER_CSUM_EN
        if (link_ready) state_n = CSUM;
`else
        last = 1'b1;
        if (link_ready) state_n = IDLE;
`endif
      end
`ifdef FLIT_SERIALIZER_CSUM_EN
      CSUM: begin
        link_valid = 1'b1;
        link_data  = hold[47:32] ^ hold[31:16] ^ hold[15:0];
        link_type  = 2'b11;
        last       = 1'b1;
        if (link_ready) state_n = IDLE;
      end
`endif
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_flit_serializer.sv
// Bench for flit_serializer: table of known packets, hand-written corner
// sequences (stall, back-to-back, mid-packet reset, counter wrap) and a
// randomized run against a packet-level reference model.
// A narrow counter (CNT_W=4) keeps the wrap case within a short run.
module tb_flit_serializer;
  localparam int CNT_W = 4;
`ifdef FLIT_SERIALIZER_CSUM_EN
  localparam int NW = 4;
  localparam int PERIOD = 6;
`else
  localparam int NW = 3;
  localparam int PERIOD = 5;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             fifo_empty;
  logic             fifo_rd_en;
  logic [47:0]      fifo_dout;
  logic [15:0]      link_data;
  logic [1:0]       link_type;
  logic             link_valid;
  logic             link_ready;
  logic             busy;
  logic [CNT_W-1:0] pkt_count;

  always #5 clk = ~clk;

  flit_serializer #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
    .fifo_dout(fifo_dout), .link_data(link_data), .link_type(link_type),
    .link_valid(link_valid), .link_ready(link_ready), .busy(busy), .pkt_count(pkt_count)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Reference model: upstream FIFO, expected word stream, finished-packet count.
  typedef struct {logic [15:0] d; logic [1:0] t;} word_t;
  typedef struct {logic [15:0] d; logic [1:0] t; int cyc;} got_t;
  logic [47:0] fq[$];
  word_t       exp_q[$];
  got_t        got_q[$];
  int          head_cyc[$];
  int          done_pkts = 0;
  int          body_cyc = 0;
  int          cyc = 0;
  logic        stall_p = 1'b0;
  logic [17:0] stall_w = '0;

  task automatic push_pkt(input logic [47:0] p);
    fq.push_back(p);
    fifo_empty = 1'b0;
  endtask

  // FIFO model: dout valid the cycle after a pop; each pop predicts the words.
  always @(posedge clk) begin
    if (fifo_rd_en && fq.size() > 0) begin
      logic [47:0] p;
      word_t w;
      p = fq.pop_front();
      fifo_dout  <= p;
      fifo_empty <= (fq.size() == 0);
      w.d = p[47:32]; w.t = 2'b00; exp_q.push_back(w);
      w.d = p[31:16]; w.t = 2'b01; exp_q.push_back(w);
      w.d = p[15:0];  w.t = 2'b10; exp_q.push_back(w);
`ifdef FLIT_SERIALIZER_CSUM_EN
      w.d = p[47:32] ^ p[31:16] ^ p[15:0]; w.t = 2'b11; exp_q.push_back(w);
`endif
    end
  end

  // Monitor, sampled mid-cycle: link protocol rules and word-by-word scoreboard.
  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      stall_p = 1'b0;
    end else begin
      chk("pkt_count_model", pkt_count, done_pkts % (1 << CNT_W));
      chk("pop_only_idle", fifo_rd_en && busy, 0);
      if (!link_valid) chk("zero_when_invalid", {link_data, link_type}, 0);
`ifndef FLIT_SERIALIZER_CSUM_EN
      if (link_valid) chk("no_type_11", link_type == 2'b11, 0);
`endif
      if (stall_p) chk("stall_hold", {link_valid, link_data, link_type}, {1'b1, stall_w});
      if (link_valid && link_type == 2'b01) body_cyc++;
      if (link_valid && link_ready) begin
        got_t g;
        g.d = link_data; g.t = link_type; g.cyc = cyc;
        got_q.push_back(g);
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL extra_word actual=%0h/%0d expected=none", link_data, link_type);
        end else begin
          word_t w;
          w = exp_q.pop_front();
          chk("word", {link_data, link_type}, {w.d, w.t});
          if (w.t == 2'b00) head_cyc.push_back(cyc);
          if (exp_q.size() % NW == 0) done_pkts++;
        end
      end
      stall_p = link_valid && !link_ready;
      stall_w = {link_data, link_type};
    end
  end

  task automatic wait_idle(input string nm, input int budget);
    int n = 0;
    while ((fq.size() != 0 || exp_q.size() != 0 || busy) && n < budget) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (n >= budget) begin
      failures++;
      $display("FAIL %s timeout actual=%0d cycles expected<%0d", nm, n, budget);
    end
  endtask

  task automatic chk_outputs_zero(input string nm);
    chk(nm, {fifo_rd_en, link_valid, link_data, link_type, busy, pkt_count}, 0);
  endtask

  typedef struct {logic [47:0] pkt; logic [15:0] h, b, t, c;} vec_t;
  vec_t vec[4];

  initial begin
    vec[0] = '{48'h1111_2222_3333, 16'h1111, 16'h2222, 16'h3333, 16'h0000};
    vec[1] = '{48'h00FF_0F0F_F000, 16'h00FF, 16'h0F0F, 16'hF000, 16'hFFF0};
    vec[2] = '{48'hDEAD_BEEF_1234, 16'hDEAD, 16'hBEEF, 16'h1234, 16'h7276};
    vec[3] = '{48'hFFFF_0000_FFFF, 16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000};

    reset = 1'b1; fifo_empty = 1'b1; link_ready = 1'b0; fifo_dout = '0;
    repeat (2) @(posedge clk);
    #1 chk_outputs_zero("reset_state");
    push_pkt(48'h1111_2222_3333);
    #1 chk("no_pop_in_reset", fifo_rd_en, 0);
    @(posedge clk); #1;
    chk("no_pop_in_reset_edge", fifo_rd_en, 0);
    reset = 1'b0;
    #1 chk("pop_after_release", fifo_rd_en, 1);
    link_ready = 1'b1;
    wait_idle("drain_first", 50);

    // Table: known packets, continuous ready, words on consecutive cycles.
    for (int i = 0; i < 4; i++) begin
      got_q.delete();
      push_pkt(vec[i].pkt);
      wait_idle("table", 50);
      chk("table_nwords", got_q.size(), NW);
      if (got_q.size() == NW) begin
        chk("table_head", {got_q[0].d, got_q[0].t}, {vec[i].h, 2'b00});
        chk("table_body", {got_q[1].d, got_q[1].t}, {vec[i].b, 2'b01});
        chk("table_tail", {got_q[2].d, got_q[2].t}, {vec[i].t, 2'b10});
`ifdef FLIT_SERIALIZER_CSUM_EN
        chk("table_csum", {got_q[3].d, got_q[3].t}, {vec[i].c, 2'b11});
`endif
        chk("table_consec", got_q[NW-1].cyc - got_q[0].cyc, NW - 1);
      end
    end
    chk("table_count", pkt_count, 5);

    // Stall three cycles in BODY: body word visible four cycles, no dup/skip.
    got_q.delete(); body_cyc = 0; link_ready = 1'b0;
    push_pkt(48'h1111_2222_3333);
    for (int n = 0; n < 20 && !link_valid; n++) begin @(posedge clk); #1; end
    chk("stall_reach_head", {link_valid, link_type}, {1'b1, 2'b00});
    link_ready = 1'b1;
    @(posedge clk); #1;
    link_ready = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    link_ready = 1'b1;
    wait_idle("stall", 50);
    chk("stall_body_cycles", body_cyc, 4);
    chk("stall_nwords", got_q.size(), NW);
    if (got_q.size() >= 3) chk("stall_body_word", {got_q[1].d, got_q[1].t}, {16'h2222, 2'b01});

    // Back-to-back packets: minimum packet period.
    head_cyc.delete();
    push_pkt(48'h0102_0304_0506);
    push_pkt(48'h0708_090A_0B0C);
    wait_idle("b2b", 60);
    chk("b2b_heads", head_cyc.size(), 2);
    if (head_cyc.size() == 2) chk("b2b_period", head_cyc[1] - head_cyc[0], PERIOD);
    chk("b2b_count", pkt_count, 8);

    // Reset during BODY: outputs clear at once, held packet is dropped.
    push_pkt(48'hAAAA_BBBB_CCCC);
    for (int n = 0; n < 20 && !(link_valid && link_type == 2'b01); n++) begin @(posedge clk); #1; end
    chk("rst_reach_body", {link_valid, link_type}, {1'b1, 2'b01});
    reset = 1'b1;
    fq.delete(); exp_q.delete(); got_q.delete(); done_pkts = 0; fifo_empty = 1'b1;
    #1 chk_outputs_zero("rst_mid_zero");
    @(posedge clk); #1;
    reset = 1'b0;
    push_pkt(48'h0001_0002_0003);
    wait_idle("rst_next", 50);
    chk("rst_nwords", got_q.size(), NW);
    if (got_q.size() > 0) chk("rst_first_head", {got_q[0].d, got_q[0].t}, {16'h0001, 2'b00});
    chk("rst_count", pkt_count, 1);

    // Counter wrap: all-ones then one more packet reaches zero.
    for (int i = 0; i < 14; i++) push_pkt(48'h0 + i);
    wait_idle("wrap_fill", 200);
    chk("wrap_all_ones", pkt_count, 4'hF);
    push_pkt(48'h1234_5678_9ABC);
    wait_idle("wrap_one", 50);
    chk("wrap_zero", pkt_count, 0);
    chk("wrap_quiet", {busy, link_valid, link_data, link_type}, 0);

    // Random traffic and random backpressure against the model.
    for (int n = 0, sent = 0; n < 4000 && sent < 200; n++) begin
      if ($urandom_range(0, 2) != 0) begin
        logic [47:0] p;
        p[31:0]  = $urandom();
        p[47:32] = 16'($urandom_range(0, 65535));
        push_pkt(p);
        sent++;
      end
      link_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    link_ready = 1'b1;
    wait_idle("random", 3000);
    chk("random_count", pkt_count, done_pkts % (1 << CNT_W));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
